key_search_scheduler: RTL
=========================

Name: key_search_scheduler

Overview:
Top-level sequencer for the brute-force RC4 key search. It walks the inclusive key range KEY_LOWER..KEY_UPPER and dispatches one 24-bit candidate key per cycle to idle decryption cores, chosen round-robin. It stops on the first core that reports a valid plaintext, or when the range is exhausted and all cores have drained. It replaces per-core free-running key generators so that N_CORES cores share one key space with no overlap.

Parameters:
N_CORES, 4, number of decryption cores served (1..16)
KEY_LOWER, 24'h000000, first key dispatched
KEY_UPPER, 24'h3FFFFF, last key dispatched (inclusive, >= KEY_LOWER)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
start  in  1  single-cycle pulse; begins a search, accepted only in IDLE
core_done  in  N_CORES  per-core pulse: candidate finished
core_hit  in  N_CORES  per-core, valid only with core_done: key decrypted valid text
core_start  out  N_CORES  one-hot pulse: core i loads core_key
core_key  out  24  key for the core pulsed on core_start
core_abort  out  1  one-cycle pulse to all cores on hit or when start is accepted
busy  out  1  high from start acceptance to the end of the search
found  out  1  search ended with a hit; held until next start
exhausted  out  1  search ended without a hit; held until next start
found_key  out  24  winning key; valid while found=1

Behaviour:
- Reset values: all outputs 0; state IDLE; internal key counter = KEY_LOWER; all cores marked idle; RR pointer = 0.
- Reset applied mid-search returns the block to IDLE at once. Cores are not aborted by this block; they share the same reset.
- States and transitions:
  - IDLE: on start, pulse core_abort, clear found/exhausted, load counter with KEY_LOWER, set busy, go to DISPATCH.
  - DISPATCH: each cycle, if any core is idle, pick one via round-robin starting at the RR pointer. Pulse its core_start bit, drive core_key = counter, record the key in a per-core register, mark the core busy, advance the RR pointer past it. If the key dispatched was KEY_UPPER, go to DRAIN; otherwise increment the counter. At most one dispatch per cycle.
  - DRAIN: no dispatch. When all cores are idle and no hit has occurred, set exhausted, clear busy, go to IDLE.
  - Hit, in DISPATCH or DRAIN: core_done[i] & core_hit[i] takes priority over dispatch, so there is no core_start in that cycle. Latch found_key from core i's key register, set found, pulse core_abort next cycle, clear busy, go to IDLE.
- The last-key test is an equality compare before increment, so KEY_UPPER = 24'hFFFFFF never wraps the counter.
- Latency: first core_start comes 1 cycle after start is accepted. A core freed by core_done in cycle t can be re-dispatched in cycle t+1.
- Simultaneous events:
  - Multiple hits in one cycle: lowest index wins.
  - core_done without core_hit frees the core.
  - core_done from an idle core is ignored.
  - start while busy is ignored.
- Outputs are registered; core_start and core_key are valid in the same cycle.

Optional Feature:
KEY_SCHED_PERF_EN. When defined, adds output perf_cycles[31:0]: it clears on start acceptance, counts cycles while busy, saturates at all-ones, and holds after the search ends. When undefined, the port and counter do not exist and behaviour is otherwise identical.

Decomposition:
- Package key_search_pkg: KEY_W = 24; typedef key_t = logic [KEY_W-1:0]; enum sched_state_t {IDLE, DISPATCH, DRAIN}.
- Sub-module rr_arbiter (parameter N): inputs req[N] and pointer; outputs a one-hot grant and a valid flag. It is combinational and is instantiated once for idle-core selection.

Test Plan:
- N_CORES=2, KEY_LOWER=0, KEY_UPPER=3. Cores answer done/no-hit 4 cycles after start. Pulse start -> keys 0,1,2,3 dispatched to cores 0,1,0,1; exhausted=1, found=0, busy drops.
- Same setup, core 1 reports hit on key 1 -> found=1, found_key=24'h000001, core_abort pulses once, no further core_start.
- Cores 0 and 2 report hit in the same cycle -> found_key equals core 0's key.
- KEY_LOWER = KEY_UPPER = 24'hFFFFFF -> exactly one dispatch with core_key=24'hFFFFFF, no wrap, exhausted=1.
- Assert reset low during DISPATCH -> all outputs 0 at once. A new start after release restarts from KEY_LOWER.
- With KEY_SCHED_PERF_EN defined, run scenario 1 -> perf_cycles equals the number of cycles busy was high.

Source files
------------

// File: rtl/key_search_pkg.sv
// Shared types for the RC4 key-search scheduler.
// Key width, key type and sequencer state encoding.
package key_search_pkg;

  localparam int KEY_W = 24;

  typedef logic [KEY_W-1:0] key_t;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    DRAIN
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick among requesters.
// Ports: req (N), ptr (search origin), grant (one-hot), valid.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);

  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!valid && req[(int'(ptr) + k) % N]) begin
        grant[(int'(ptr) + k) % N] = 1'b1;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_search_scheduler.sv
// Key-range sequencer: hands one key per cycle to idle cores (round-robin),
// stops on first hit or when the range is exhausted and all cores drained.
// Ports: clk, reset (async, active-low), start, core_done/core_hit (in),
// core_start/core_key/core_abort, busy/found/exhausted/found_key (out).
// Option KEY_SCHED_PERF_EN adds perf_cycles (busy-cycle counter, saturating).
module key_search_scheduler
  import key_search_pkg::*;
#(
  parameter int   N_CORES   = 4,
  parameter key_t KEY_LOWER = 24'h000000,
  parameter key_t KEY_UPPER = 24'h3FFFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_CORES-1:0] core_done,
  input  logic [N_CORES-1:0] core_hit,
  output logic [N_CORES-1:0] core_start,
  output key_t               core_key,
  output logic               core_abort,
  output logic               busy,
  output logic               found,
  output logic               exhausted,
`ifdef KEY_SCHED_PERF_EN
  output logic [31:0]        perf_cycles,
`endif
  output key_t               found_key
);

  localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  sched_state_t      state_q, state_d;
  key_t              cnt_q, cnt_d;
  logic [N_CORES-1:0] cbusy_q, cbusy_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  key_t              kreg_q [N_CORES];
  key_t              kreg_d [N_CORES];
  logic [N_CORES-1:0] cstart_q, cstart_d;
  key_t              ckey_q, ckey_d;
  logic              abort_q, abort_d;
  logic              busy_q, busy_d;
  logic              found_q, found_d;
  logic              exh_q, exh_d;
  key_t              fkey_q, fkey_d;

  logic [N_CORES-1:0] grant;
  logic               gvalid;
  logic [PW-1:0]      gidx;
  logic [N_CORES-1:0] hits;
  logic [PW-1:0]      hidx;

  rr_arbiter #(
    .N  (N_CORES),
    .PW (PW)
  ) u_arb (
    .req   (~cbusy_q),
    .ptr   (ptr_q),
    .grant (grant),
    .valid (gvalid)
  );

  // Reports from cores we never dispatched to are ignored.
  assign hits = core_done & core_hit & cbusy_q;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_CORES; i++)
      if (grant[i]) gidx = PW'(i);
  end

  // Descending scan so the lowest hitting index wins.
  always_comb begin
    hidx = '0;
    for (int i = N_CORES - 1; i >= 0; i--)
      if (hits[i]) hidx = PW'(i);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cbusy_d  = cbusy_q & ~core_done;
    ptr_d    = ptr_q;
    kreg_d   = kreg_q;
    cstart_d = '0;
    ckey_d   = ckey_q;
    abort_d  = 1'b0;
    busy_d   = busy_q;
    found_d  = found_q;
    exh_d    = exh_q;
    fkey_d   = fkey_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          abort_d = 1'b1;
          found_d = 1'b0;
          exh_d   = 1'b0;
          cnt_d   = KEY_LOWER;
          busy_d  = 1'b1;
          cbusy_d = '0;
          state_d = DISPATCH;
        end
      end
      DISPATCH, DRAIN: begin
        if (|hits) begin
          fkey_d  = kreg_q[hidx];
          found_d = 1'b1;
          abort_d = 1'b1;
          busy_d  = 1'b0;
          cbusy_d = '0;
          state_d = IDLE;
        end else if (state_q == DISPATCH) begin
          if (gvalid) begin
            cstart_d     = grant;
            ckey_d       = cnt_q;
            kreg_d[gidx] = cnt_q;
            cbusy_d      = cbusy_d | grant;
            ptr_d        = (gidx == PW'(N_CORES - 1)) ?
                           '0 : gidx + PW'(1);
            // Compare before increment: no wrap at 24'hFFFFFF.
            if (cnt_q == KEY_UPPER) state_d = DRAIN;
            else cnt_d = cnt_q + key_t'(1);
          end
        end else if (cbusy_q == '0) begin
          exh_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= KEY_LOWER;
      cbusy_q  <= '0;
      ptr_q    <= '0;
      kreg_q   <= '{default: '0};
      cstart_q <= '0;
      ckey_q   <= '0;
      abort_q  <= 1'b0;
      busy_q   <= 1'b0;
      found_q  <= 1'b0;
      exh_q    <= 1'b0;
      fkey_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cbusy_q  <= cbusy_d;
      ptr_q    <= ptr_d;
      kreg_q   <= kreg_d;
      cstart_q <= cstart_d;
      ckey_q   <= ckey_d;
      abort_q  <= abort_d;
      busy_q   <= busy_d;
      found_q  <= found_d;
      exh_q    <= exh_d;
      fkey_q   <= fkey_d;
    end
  end

  assign core_start = cstart_q;
  assign core_key   = ckey_q;
  assign core_abort = abort_q;
  assign busy       = busy_q;
  assign found      = found_q;
  assign exhausted  = exh_q;
  assign found_key  = fkey_q;

`ifdef KEY_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == IDLE && start) perf_d = '0;
    else if (busy_q && perf_q != '1) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule
